// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
//   Branch predictor and D-stage branch resolution for a MIPS-style pipeline.
//   A direct-mapped table holds a 2-bit saturating counter, a valid bit, a tag
//   and a target per entry. It is looked up combinationally from pc_f and
//   trained on the clock edge at D-stage resolution. After reset a clear FSM
//   walks every entry, one per cycle. Predictions are forced not-taken while it
//   runs.
//
//   Handshake: there is no valid/ready pair. resolve_valid_d qualifies D-stage
//   work, and stall_d holds D. Training and perf counting happen only on an
//   edge where resolve_valid_d & branch_d & !stall_d & !busy.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   stall_d                 D stalled: no training, perf counters hold
//   pc_f                    F-stage lookup PC
//   pred_taken_f/target_f   F prediction (target is 0 when not taken)
//   busy                    clear FSM running
//   resolve_valid_d, branch_d, equal_d, pc_d, target_d,
//   pred_taken_d, pred_target_d   D-stage resolution inputs
//   pcsrc_d, mispredict_d, redirect_pc_d   D-stage resolution outputs
//   perf_branches, perf_mispredicts        wrapping event counters
//   dbg_state               clear FSM state (0 = CLEAR, 1 = RUN)
// -----------------------------------------------------------------------------
module branch_predict_unit #(
  parameter int          IDX_BITS = 6,
  parameter int          TAG_BITS = 8,
  parameter logic [1:0]  CNT_INIT = 2'b01,
  parameter int          PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_d,
  input  logic [31:0]       pc_f,
  output logic              pred_taken_f,
  output logic [31:0]       pred_target_f,
  output logic              busy,
  input  logic              resolve_valid_d,
  input  logic              branch_d,
  input  logic              equal_d,
  input  logic [31:0]       pc_d,
  input  logic [31:0]       target_d,
  input  logic              pred_taken_d,
  input  logic [31:0]       pred_target_d,
  output logic              pcsrc_d,
  output logic              mispredict_d,
  output logic [31:0]       redirect_pc_d,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts,
  output logic              dbg_state
);

  localparam int ENTRIES = 1 << IDX_BITS;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [IDX_BITS-1:0]   clr_idx_q, clr_idx_d;
  logic [PERF_W-1:0]     perf_br_q, perf_br_d;
  logic [PERF_W-1:0]     perf_mis_q, perf_mis_d;

  logic [1:0]            bht_cnt_q   [ENTRIES];
  logic [1:0]            bht_cnt_d   [ENTRIES];
  logic                  btb_valid_q [ENTRIES];
  logic                  btb_valid_d [ENTRIES];
  logic [TAG_BITS-1:0]   btb_tag_q   [ENTRIES];
  logic [TAG_BITS-1:0]   btb_tag_d   [ENTRIES];
  logic [31:0]           btb_tgt_q   [ENTRIES];
  logic [31:0]           btb_tgt_d   [ENTRIES];

  logic [IDX_BITS-1:0]   f_idx, r_idx;
  logic [TAG_BITS-1:0]   f_tag, r_tag;
  logic                  f_hit, r_hit, train;
  logic [1:0]            r_cnt;
  logic                  unused_pc_bits;

  assign f_idx = pc_f[IDX_BITS+1:2];
  assign f_tag = pc_f[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign r_idx = pc_d[IDX_BITS+1:2];
  assign r_tag = pc_d[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign unused_pc_bits = ^{pc_f[31:IDX_BITS+TAG_BITS+2], pc_f[1:0]};

  assign busy      = (state_q == ST_CLEAR);
  assign dbg_state = state_q;

  // F lookup reads the registered table, so a same-cycle D write to the
  // same index is only visible to F on the following cycle.
  always_comb begin
    f_hit         = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
    pred_taken_f  = !busy && f_hit && bht_cnt_q[f_idx][1];
    pred_target_f = pred_taken_f ? btb_tgt_q[f_idx] : 32'd0;
  end

  // D resolution is purely combinational and independent of reset.
  always_comb begin
    pcsrc_d       = branch_d & equal_d;
    mispredict_d  = resolve_valid_d & !stall_d &
                    ((pcsrc_d & (!pred_taken_d | (pred_target_d != target_d))) |
                     (!pcsrc_d & pred_taken_d));
    redirect_pc_d = pcsrc_d ? target_d : pc_d + 32'd8;
    train         = resolve_valid_d & branch_d & !stall_d & !busy;
  end

  // Clear FSM: one entry per cycle, RUN after the last index is written.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + IDX_BITS'(1);
        if (clr_idx_q == IDX_BITS'(ENTRIES - 1)) state_d = ST_RUN;
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Table update: clear write while busy, otherwise training.
  always_comb begin
    bht_cnt_d   = bht_cnt_q;
    btb_valid_d = btb_valid_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    r_hit       = btb_valid_q[r_idx] && (btb_tag_q[r_idx] == r_tag);
    r_cnt       = bht_cnt_q[r_idx];
    if (busy) begin
      bht_cnt_d[clr_idx_q]   = CNT_INIT;
      btb_valid_d[clr_idx_q] = 1'b0;
    end else if (train) begin
      if (r_hit) begin
        if (pcsrc_d) bht_cnt_d[r_idx] = (r_cnt == 2'b11) ? 2'b11 : r_cnt + 2'd1;
        else         bht_cnt_d[r_idx] = (r_cnt == 2'b00) ? 2'b00 : r_cnt - 2'd1;
      end else begin
        // A cold or aliased entry restarts at the weak state of the outcome.
        bht_cnt_d[r_idx] = pcsrc_d ? 2'b10 : 2'b01;
      end
      if (pcsrc_d) begin
        btb_valid_d[r_idx] = 1'b1;
        btb_tag_d[r_idx]   = r_tag;
        btb_tgt_d[r_idx]   = target_d;
      end
    end
  end

  always_comb begin
    perf_br_d  = perf_br_q + PERF_W'(train);
    perf_mis_d = perf_mis_q + PERF_W'(train & mispredict_d);
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      perf_br_q  <= perf_br_d;
      perf_mis_q <= perf_mis_d;
    end
  end

  // Table storage has no reset; the clear FSM initialises it.
  always_ff @(posedge clk) begin
    bht_cnt_q   <= bht_cnt_d;
    btb_valid_q <= btb_valid_d;
    btb_tag_q   <= btb_tag_d;
    btb_tgt_q   <= btb_tgt_d;
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        stall_d = 1'b0;
  logic [31:0] pc_f = '0;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        busy;
  logic        resolve_valid_d = 1'b0;
  logic        branch_d = 1'b0;
  logic        equal_d = 1'b0;
  logic [31:0] pc_d = '0;
  logic [31:0] target_d = '0;
  logic        pred_taken_d = 1'b0;
  logic [31:0] pred_target_d = '0;
  logic        pcsrc_d;
  logic        mispredict_d;
  logic [31:0] redirect_pc_d;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
  logic        dbg_state;

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .stall_d(stall_d), .pc_f(pc_f),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f), .busy(busy),
    .resolve_valid_d(resolve_valid_d), .branch_d(branch_d), .equal_d(equal_d),
    .pc_d(pc_d), .target_d(target_d), .pred_taken_d(pred_taken_d),
    .pred_target_d(pred_target_d), .pcsrc_d(pcsrc_d), .mispredict_d(mispredict_d),
    .redirect_pc_d(redirect_pc_d), .perf_branches(perf_branches),
    .perf_mispredicts(perf_mispredicts), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  int          m_cnt   [64];
  bit          m_valid [64];
  int          m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_clear_left;
  logic [31:0] m_br, m_mis;

  function automatic int m_index(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int m_tagof(logic [31:0] pc);
    return int'((pc >> 8) % 256);
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    int i;
    i = m_index(pc);
    return (m_clear_left == 0) && m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_cnt[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_tgt(logic [31:0] pc);
    return m_pred(pc) ? m_tgt[m_index(pc)] : 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    m_clear_left = 64;
    m_br  = '0;
    m_mis = '0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // One clock: compare all outputs at the negedge, then advance the model.
  task automatic step();
    bit          pcsrc, mis, train, hit, mp;
    logic [31:0] rd;
    int          i;
    @(negedge clk);
    mp = m_pred(pc_f);
    check("pred_taken_f", 32'(pred_taken_f), 32'(mp));
    check("pred_target_f", pred_target_f, m_pred_tgt(pc_f));
    check("busy", 32'(busy), 32'(m_clear_left > 0));
    check("dbg_state", 32'(dbg_state), 32'(m_clear_left == 0));
    pcsrc = branch_d && equal_d;
    mis = resolve_valid_d && !stall_d &&
          ((pcsrc && (!pred_taken_d || pred_target_d != target_d)) || (!pcsrc && pred_taken_d));
    rd = pcsrc ? target_d : pc_d + 32'd8;
    check("pcsrc_d", 32'(pcsrc_d), 32'(pcsrc));
    check("mispredict_d", 32'(mispredict_d), 32'(mis));
    check("redirect_pc_d", redirect_pc_d, rd);
    check("perf_branches", perf_branches, m_br);
    check("perf_mispredicts", perf_mispredicts, m_mis);
    train = resolve_valid_d && branch_d && !stall_d && (m_clear_left == 0);
    @(posedge clk);
    if (m_clear_left > 0) m_clear_left--;
    if (train) begin
      i = m_index(pc_d);
      hit = m_valid[i] && (m_tag[i] == m_tagof(pc_d));
      if (hit) m_cnt[i] = pcsrc ? ((m_cnt[i] == 3) ? 3 : m_cnt[i] + 1)
                                : ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1);
      else     m_cnt[i] = pcsrc ? 2 : 1;
      if (pcsrc) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = m_tagof(pc_d);
        m_tgt[i]   = target_d;
      end
      m_br = m_br + 1;
      if (mis) m_mis = m_mis + 1;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    resolve_valid_d = 1'b0; branch_d = 1'b0; equal_d = 1'b0;
    pred_taken_d = 1'b0; pred_target_d = '0; stall_d = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  // Resolve a branch, carrying the prediction the F stage would have made.
  task automatic resolve(logic [31:0] pc, logic [31:0] tgt, bit taken);
    resolve_valid_d = 1'b1; branch_d = 1'b1; equal_d = taken;
    pc_d = pc; target_d = tgt;
    pred_taken_d = m_pred(pc); pred_target_d = m_pred_tgt(pc);
    step();
  endtask

  task automatic count_busy(string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      pc_f = $urandom;
      step();
      n++;
    end
    check(name, n, 64);
  endtask

  logic [31:0] pool [8];
  logic [31:0] saved;

  initial begin
    pool[0] = 32'h0040_0010; pool[1] = 32'h0040_1010; pool[2] = 32'h0040_0014;
    pool[3] = 32'h0040_2020; pool[4] = 32'h0041_0010; pool[5] = 32'h0040_00fc;
    pool[6] = 32'h0000_1000; pool[7] = 32'h0050_0020;

    // Test 1: reset and clear duration
    do_reset();
    check("busy_after_reset", 32'(busy), 32'd1);
    check("perf_br_reset", perf_branches, 32'd0);
    check("perf_mis_reset", perf_mispredicts, 32'd0);
    count_busy("busy_cycles");

    // Test 2: train twice, then predict
    pc_f = 32'h0040_0010;
    resolve(32'h0040_0010, 32'h0040_0100, 1'b1);
    resolve(32'h0040_0010, 32'h0040_0100, 1'b1);
    idle(); #1;
    check("t2_pred", 32'(pred_taken_f), 32'd1);
    check("t2_target", pred_target_f, 32'h0040_0100);
    step();

    // Test 3: cold taken mispredict, predicted-taken resolves not-taken
    resolve_valid_d = 1'b1; branch_d = 1'b1; equal_d = 1'b1;
    pc_d = 32'h0050_0020; target_d = 32'h0050_0200; pred_taken_d = 1'b0; pred_target_d = '0;
    #1;
    check("t3_cold_mis", 32'(mispredict_d), 32'd1);
    check("t3_cold_redir", redirect_pc_d, 32'h0050_0200);
    step();
    equal_d = 1'b0; pc_d = 32'h0000_1000; target_d = 32'h0000_2000;
    pred_taken_d = 1'b1; pred_target_d = 32'h0000_2000;
    #1;
    check("t3_nt_mis", 32'(mispredict_d), 32'd1);
    check("t3_nt_redir", redirect_pc_d, 32'h0000_1008);
    step();
    branch_d = 1'b0; pred_taken_d = 1'b0; pc_d = 32'hffff_fffc;
    #1;
    check("t3_wrap_redir", redirect_pc_d, 32'h0000_0004);
    step();

    // Test 4: saturation
    pc_f = 32'h0040_2020;
    repeat (5) resolve(32'h0040_2020, 32'h0040_2400, 1'b1);
    resolve(32'h0040_2020, 32'h0040_2400, 1'b0);
    idle(); #1;
    check("t4_still_taken", 32'(pred_taken_f), 32'd1);
    repeat (2) resolve(32'h0040_2020, 32'h0040_2400, 1'b0);
    idle(); #1;
    check("t4_now_nt", 32'(pred_taken_f), 32'd0);

    // Test 5: aliasing
    pc_f = 32'h0040_1010; #1;
    check("t5_alias_nopred", 32'(pred_taken_f), 32'd0);
    resolve(32'h0040_1010, 32'h0040_1100, 1'b1);
    idle(); #1;
    check("t5_new_pred", 32'(pred_taken_f), 32'd1);
    check("t5_new_tgt", pred_target_f, 32'h0040_1100);
    pc_f = 32'h0040_0010; #1;
    check("t5_old_evicted", 32'(pred_taken_f), 32'd0);
    step();

    // Test 6: same-cycle read/write of one index
    pc_f = 32'h0040_3030;
    resolve_valid_d = 1'b1; branch_d = 1'b1; equal_d = 1'b1;
    pc_d = 32'h0040_3030; target_d = 32'h0040_3300; pred_taken_d = 1'b0; pred_target_d = '0;
    #1;
    check("t6_raw_old", 32'(pred_taken_f), 32'd0);
    step();
    idle(); #1;
    check("t6_raw_new", 32'(pred_taken_f), 32'd1);

    // stall suppresses training and perf counting
    saved = m_br;
    pc_f = 32'h0040_4040;
    stall_d = 1'b1; resolve_valid_d = 1'b1; branch_d = 1'b1; equal_d = 1'b1;
    pc_d = 32'h0040_4040; target_d = 32'h0040_4400;
    repeat (3) step();
    idle(); #1;
    check("t6_stall_perf", perf_branches, saved);
    check("t6_stall_nopred", 32'(pred_taken_f), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      pc_f = pool[$urandom_range(0, 7)];
      resolve_valid_d = ($urandom_range(0, 9) != 0);
      branch_d = ($urandom_range(0, 4) != 0);
      equal_d = $urandom_range(0, 1);
      stall_d = ($urandom_range(0, 9) == 0);
      pc_d = ($urandom_range(0, 15) == 0) ? $urandom : pool[$urandom_range(0, 7)];
      target_d = ($urandom_range(0, 3) == 0) ? $urandom : pc_d + 32'h100;
      if ($urandom_range(0, 3) != 0) begin
        pred_taken_d = m_pred(pc_d); pred_target_d = m_pred_tgt(pc_d);
      end else begin
        pred_taken_d = $urandom_range(0, 1); pred_target_d = pc_d + 32'h100;
      end
      step();
    end
    idle();

    // Reset mid-clear restarts the walk from index 0
    do_reset();
    repeat (20) step();
    do_reset();
    count_busy("busy_cycles_restart");
    for (int k = 0; k < 8; k++) begin
      pc_f = pool[k];
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
